iob_split_tracked: RTL

IOB_SPLIT_TRACKED -- requirements
Module: iob_split_tracked

---
 rtl/iob_split_tracked_pkg.sv | 14 +
 rtl/iob_split_tracker.sv | 65 ++++++
 rtl/iob_split_tracked.sv | 98 +++++++++
 3 files changed

// File: rtl/iob_split_tracked_pkg.sv
// Shared helpers for the tracked split interconnect: slave-select field width
// and outstanding-counter width.
package iob_split_tracked_pkg;

    // Width of the slave-select field; never narrower than one bit.
    function automatic int unsigned sel_bits(input int unsigned n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

    function automatic int unsigned cnt_bits(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/iob_split_tracker.sv
// In-order read tracker: outstanding count, owning slave of the in-flight reads,
// and the one-cycle error response for reads to unmapped slaves.
module iob_split_tracker
    import iob_split_tracked_pkg::*;
#(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned MAX_OUT  = 4,
    parameter int unsigned NB       = sel_bits(N_SLAVES),
    parameter int unsigned CW       = cnt_bits(MAX_OUT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_accept,
    input  logic [NB:0]         rd_sel,
    input  logic [N_SLAVES-1:0] s_rvalid,
    output logic [CW-1:0]       cnt,
    output logic [NB:0]         cur_sel,
    output logic                resp_valid,
    output logic                resp_err
);

    localparam logic [NB:0]   NSel   = (NB + 1)'(N_SLAVES);
    localparam logic [CW-1:0] CntMax = CW'(MAX_OUT);

    logic [CW-1:0] cnt_q;
    logic [NB:0]   cur_sel_q;
    logic          err_pend_q;

    assign cnt     = cnt_q;
    assign cur_sel = cur_sel_q;

    always_comb begin
        resp_err   = (cur_sel_q >= NSel);
        resp_valid = 1'b0;
        if (resp_err) begin
            resp_valid = err_pend_q;
        end else begin
            for (int i = 0; i < int'(N_SLAVES); i++) begin
                if (cur_sel_q == (NB + 1)'(i)) begin
                    resp_valid = s_rvalid[i] && (cnt_q != '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            cur_sel_q  <= '0;
            err_pend_q <= 1'b0;
        end else begin
            // Unmapped reads are answered exactly one cycle after acceptance.
            err_pend_q <= rd_accept && (rd_sel >= NSel);
            if (rd_accept) begin
                cur_sel_q <= rd_sel;
            end
            if (rd_accept && !resp_valid && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!rd_accept && resp_valid && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_split_tracked.sv
// One-master to N-slave request splitter; reads stay in order by only letting
// reads to a single slave be in flight at a time.
module iob_split_tracked
    import iob_split_tracked_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned P_SLAVES = ADDR_W - 1,
    parameter int unsigned MAX_OUT  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_valid,
    input  logic [ADDR_W-1:0]              m_addr,
    input  logic [DATA_W-1:0]              m_wdata,
    input  logic [DATA_W/8-1:0]            m_wstrb,
    output logic                           m_ready,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           m_rvalid,
    output logic                           m_rerr,
    output logic [N_SLAVES-1:0]            s_valid,
    output logic [N_SLAVES*ADDR_W-1:0]     s_addr,
    output logic [N_SLAVES*DATA_W-1:0]     s_wdata,
    output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb,
    input  logic [N_SLAVES-1:0]            s_ready,
    input  logic [N_SLAVES*DATA_W-1:0]     s_rdata,
    input  logic [N_SLAVES-1:0]            s_rvalid
);

    localparam int unsigned NB     = sel_bits(N_SLAVES);
    localparam int unsigned CW     = cnt_bits(MAX_OUT);
    localparam logic [NB:0] NSel   = (NB + 1)'(N_SLAVES);
    localparam logic [CW-1:0] CntMax = CW'(MAX_OUT);

    logic [NB:0]   sel;
    logic          is_read;
    logic          blocked;
    logic          slave_ready;
    logic          rd_accept;
    logic [CW-1:0] cnt;
    logic [NB:0]   cur_sel;
    logic          resp_valid;
    logic          resp_err;

    assign sel     = {1'b0, m_addr[P_SLAVES -: NB]};
    assign is_read = (m_wstrb == '0);

    assign s_addr  = {N_SLAVES{m_addr}};
    assign s_wdata = {N_SLAVES{m_wdata}};
    assign s_wstrb = {N_SLAVES{m_wstrb}};

    // A full tracker still accepts in the cycle a response frees a slot.
    assign blocked = is_read && (((cnt == CntMax) && !resp_valid) ||
                                 ((cnt != '0) && (sel != cur_sel)));

    always_comb begin
        s_valid     = '0;
        slave_ready = (sel >= NSel);
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (sel == (NB + 1)'(i)) begin
                slave_ready = s_ready[i];
                s_valid[i]  = rst && m_valid && !blocked;
            end
        end
        m_ready  = rst && slave_ready && !blocked;
        m_rvalid = rst && resp_valid;
        m_rerr   = m_rvalid && resp_err;
        m_rdata  = '0;
        if (m_rvalid && !resp_err) begin
            for (int i = 0; i < int'(N_SLAVES); i++) begin
                if (cur_sel == (NB + 1)'(i)) begin
                    m_rdata = s_rdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign rd_accept = m_valid && m_ready && is_read;

    iob_split_tracker #(
        .N_SLAVES (N_SLAVES),
        .MAX_OUT  (MAX_OUT),
        .NB       (NB),
        .CW       (CW)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .rd_accept  (rd_accept),
        .rd_sel     (sel),
        .s_rvalid   (s_rvalid),
        .cnt        (cnt),
        .cur_sel    (cur_sel),
        .resp_valid (resp_valid),
        .resp_err   (resp_err)
    );

endmodule
